// File: rtl/imul_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : imul_accumulator
//  Purpose  : Multiply-accumulate back end for the 16x16 array multiplier.
//             Accepts a programmed number of 32-bit unsigned products over a
//             valid/ready handshake and sums them into a wide accumulator,
//             then pulses oDone for one cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ACC_W      accumulator width in bits (>= 32)
//    CNT_W      length counter width; max terms per run = 2^CNT_W - 1
//  Ports
//    Clock      system clock, rising edge
//    Reset      asynchronous, active-low reset
//    iStart     start request, sampled only in IDLE
//    iLength    number of products to accumulate, sampled with iStart
//    iProduct   unsigned product from the multiplier
//    iValid     iProduct valid this cycle
//    oReady     block accepts iProduct this cycle (ACCUM state)
//    oAccum     registered accumulated sum
//    oDone      one-cycle pulse, run complete and oAccum final
//    oBusy      high in ACCUM state
//    oOverflow  sticky overflow flag for the current run
//  Build option
//    IMUL_ACC_SAT_EN  when defined, oAccum saturates at 2^ACC_W-1 on
//                     overflow instead of wrapping.
// ============================================================================
module imul_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic [CNT_W-1:0] iLength,
    input  logic [31:0]      iProduct,
    input  logic             iValid,
    output logic             oReady,
    output logic [ACC_W-1:0] oAccum,
    output logic             oDone,
    output logic             oBusy,
    output logic             oOverflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [ACC_W-1:0] c_ACC_MAX = {ACC_W{1'b1}};

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [ACC_W-1:0] r_accum;
    logic             r_done;
    logic             r_overflow;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_next;

    // One extra bit on the adder so the carry out of bit ACC_W-1 is visible.
    assign w_sum   = {1'b0, r_accum} + {{(ACC_W + 1 - 32){1'b0}}, iProduct};
    assign w_carry = w_sum[ACC_W];

`ifdef IMUL_ACC_SAT_EN
    // Once a run has overflowed, the sum stays pinned at full scale;
    // r_overflow is cleared on every accepted start, so the clamp is per run.
    assign w_next = (w_carry || r_overflow) ? c_ACC_MAX : w_sum[ACC_W-1:0];
`else
    assign w_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_accum    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (iStart) begin
                        r_accum    <= '0;
                        r_overflow <= 1'b0;
                        if (iLength != '0) begin
                            r_count <= iLength;
                            r_state <= ACCUM;
                        end else begin
                            // Zero-length run completes immediately.
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ACCUM: begin
                    // oReady is 1 throughout ACCUM, so iValid alone means accept.
                    if (iValid) begin
                        r_accum <= w_next;
                        r_count <= r_count - c_CNT_ONE;
                        if (w_carry) begin
                            r_overflow <= 1'b1;
                        end
                        if (r_count == c_CNT_ONE) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs come straight from the state register, so there is
    // no combinational path from iValid to oReady.
    assign oReady    = (r_state == ACCUM);
    assign oBusy     = (r_state == ACCUM);
    assign oAccum    = r_accum;
    assign oDone     = r_done;
    assign oOverflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_imul_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imul_accumulator
//  Purpose  : Directed self-checking bench for imul_accumulator. Drives one
//             stimulus stream into a 40-bit and a 33-bit accumulator instance
//             and compares their outputs against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imul_accumulator;

    localparam int CNT_W = 8;

    logic             Clock;
    logic             Reset;
    logic             iStart;
    logic [CNT_W-1:0] iLength;
    logic [31:0]      iProduct;
    logic             iValid;

    logic             oReady40,    oReady33;
    logic [39:0]      oAccum40;
    logic [32:0]      oAccum33;
    logic             oDone40,     oDone33;
    logic             oBusy40,     oBusy33;
    logic             oOverflow40, oOverflow33;

    int checks = 0;
    int errors = 0;

    imul_accumulator #(.ACC_W(40), .CNT_W(CNT_W)) dut40 (
        .Clock     (Clock),
        .Reset     (Reset),
        .iStart    (iStart),
        .iLength   (iLength),
        .iProduct  (iProduct),
        .iValid    (iValid),
        .oReady    (oReady40),
        .oAccum    (oAccum40),
        .oDone     (oDone40),
        .oBusy     (oBusy40),
        .oOverflow (oOverflow40)
    );

    imul_accumulator #(.ACC_W(33), .CNT_W(CNT_W)) dut33 (
        .Clock     (Clock),
        .Reset     (Reset),
        .iStart    (iStart),
        .iLength   (iLength),
        .iProduct  (iProduct),
        .iValid    (iValid),
        .oReady    (oReady33),
        .oAccum    (oAccum33),
        .oDone     (oDone33),
        .oBusy     (oBusy33),
        .oOverflow (oOverflow33)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Status of the 40-bit instance packed as {ready, busy, done, overflow}.
    function automatic logic [3:0] st40();
        return {oReady40, oBusy40, oDone40, oOverflow40};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        iStart   = 1'b0;
        iLength  = '0;
        iProduct = '0;
        iValid   = 1'b0;
        #2 Reset = 1'b0;
        #1;
        // ---------------- reset state
        check("rst_accum40", oAccum40, 0);
        check("rst_status40", st40(), 4'b0000);
        check("rst_accum33", oAccum33, 0);
        tick();
        Reset = 1'b1;
        tick();
        check("idle_status", st40(), 4'b0000);

        // ---------------- basic run, length 3
        iStart = 1'b1; iLength = 8'd3;
        tick();
        iStart = 1'b0;
        check("basic_enter", st40(), 4'b1100);
        check("basic_accum0", oAccum40, 0);
        iValid = 1'b1; iProduct = 32'd6;
        tick();
        check("basic_acc1", oAccum40, 6);
        iProduct = 32'd35;
        tick();
        check("basic_acc2", oAccum40, 41);
        check("basic_nodone2", oDone40, 0);
        iProduct = 32'hFFFE_0001;
        tick();
        check("basic_final", oAccum40, 40'h00_FFFE_002A);
        check("basic_done", st40(), 4'b0010);
        iValid = 1'b0;
        tick();
        check("basic_idle", st40(), 4'b0000);
        check("basic_hold", oAccum40, 40'h00_FFFE_002A);

        // ---------------- handshake gaps, length 4, valid 1,0,0,1,1,0,1
        iStart = 1'b1; iLength = 8'd4; iProduct = 32'd10;
        tick();
        iStart = 1'b0;
        check("gap_clear", oAccum40, 0);
        iValid = 1'b1; tick();
        check("gap_a1", oAccum40, 10);
        iValid = 1'b0; tick();
        iValid = 1'b0; tick();
        check("gap_idle_hold", oAccum40, 10);
        iValid = 1'b1; tick();
        iValid = 1'b1; tick();
        check("gap_a3", oAccum40, 30);
        check("gap_nodone3", oDone40, 0);
        iValid = 1'b0; tick();
        check("gap_hold3", oAccum40, 30);
        check("gap_busy", st40(), 4'b1100);
        iValid = 1'b1; tick();
        check("gap_final", oAccum40, 40);
        check("gap_done", oDone40, 1);
        // keep presenting products in DONE and IDLE; none may be taken
        tick();
        check("gap_done_noaccept", oAccum40, 40);
        check("gap_done_once", oDone40, 0);
        tick();
        check("gap_idle_noaccept", oAccum40, 40);
        check("gap_idle_ready", oReady40, 0);
        iValid = 1'b0;

        // ---------------- zero length
        iStart = 1'b1; iLength = 8'd0;
        tick();
        iStart = 1'b0;
        check("zero_done", st40(), 4'b0010);
        check("zero_accum", oAccum40, 0);
        tick();
        check("zero_idle", st40(), 4'b0000);

        // ---------------- iStart ignored during ACCUM
        iStart = 1'b1; iLength = 8'd2;
        tick();
        iStart = 1'b0;
        iValid = 1'b1; iProduct = 32'd5;
        tick();
        check("ign_acc1", oAccum40, 5);
        iValid = 1'b0; iStart = 1'b1; iLength = 8'd9;
        tick();
        iStart = 1'b0;
        check("ign_accum", oAccum40, 5);
        check("ign_busy", st40(), 4'b1100);
        iValid = 1'b1; iProduct = 32'd7;
        tick();
        check("ign_final", oAccum40, 12);
        check("ign_done", oDone40, 1);
        iValid = 1'b0;
        tick();

        // ---------------- overflow on the 33-bit instance
        iStart = 1'b1; iLength = 8'd3;
        tick();
        iStart = 1'b0;
        iValid = 1'b1; iProduct = 32'hFFFF_FFFF;
        tick();
        tick();
        check("ovf_pre33", oAccum33, 33'h1_FFFF_FFFE);
        check("ovf_pre_flag33", oOverflow33, 0);
        iProduct = 32'h2;
        tick();
        iValid = 1'b0;
`ifdef IMUL_ACC_SAT_EN
        check("ovf_accum33", oAccum33, 33'h1_FFFF_FFFF);
`else
        check("ovf_accum33", oAccum33, 33'h0);
`endif
        check("ovf_flag33", oOverflow33, 1);
        check("ovf_done33", oDone33, 1);
        check("ovf_accum40", oAccum40, 40'h02_0000_0000);
        check("ovf_flag40", oOverflow40, 0);
        tick();
        check("ovf_sticky33", oOverflow33, 1);

        // ---------------- back-to-back runs (length 2 then length 1)
        iStart = 1'b1; iLength = 8'd2;
        tick();
        iStart = 1'b0;
        check("b2b_clear_ovf33", oOverflow33, 0);
        check("b2b_clear_acc33", oAccum33, 0);
        iValid = 1'b1; iProduct = 32'd100;
        tick();
        iProduct = 32'd200;
        tick();
        iValid = 1'b0;
        check("b2b_first_done", oDone40, 1);
        check("b2b_first_accum", oAccum40, 300);
        tick();
        check("b2b_gap1", st40(), 4'b0000);
        iStart = 1'b1; iLength = 8'd1;
        tick();
        iStart = 1'b0;
        check("b2b_second_clear", oAccum40, 0);
        check("b2b_gap2", st40(), 4'b1100);
        iValid = 1'b1; iProduct = 32'd7;
        tick();
        iValid = 1'b0;
        check("b2b_second_done", oDone40, 1);
        check("b2b_second_accum", oAccum40, 7);
        tick();

        // ---------------- asynchronous reset mid-run
        iStart = 1'b1; iLength = 8'd5;
        tick();
        iStart = 1'b0;
        iValid = 1'b1; iProduct = 32'd3;
        tick();
        tick();
        check("mid_pre_accum", oAccum40, 6);
        Reset = 1'b0;
        #1;
        check("mid_async_accum40", oAccum40, 0);
        check("mid_async_status40", st40(), 4'b0000);
        check("mid_async_ready33", oReady33, 0);
        tick();
        iValid = 1'b0;
        Reset = 1'b1;
        tick();
        check("mid_after_status", st40(), 4'b0000);
        check("mid_after_accum", oAccum40, 0);
        tick();
        check("mid_after_ready", oReady40, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imul_accumulator.md
# imul_accumulator

Sequential accumulate stage directly downstream of the 16x16 array multiplier. Consumes a stream of 32-bit unsigned products via a valid/ready handshake and sums a programmed number of them into a wide accumulator. Signals completion with a one-cycle done pulse. Turns the combinational multiplier into a dot-product / multiply-accumulate datapath.

## Interface
- ACC_W, 40, accumulator width in bits; must be ≥ 32.
- CNT_W, 8, width of the length counter; max terms per run = 2^CNT_W − 1.

- Clock  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- iStart  input  1  start request; sampled only in IDLE.
- iLength  input  CNT_W  number of products to accumulate; sampled with iStart.
- iProduct  input  32  unsigned product from the multiplier's oResult.
- iValid  input  1  iProduct is valid this cycle.
- oReady  output  1  block accepts iProduct this cycle.
- oAccum  output  ACC_W  accumulated sum, registered.
- oDone  output  1  one-cycle pulse: run complete, oAccum final.
- oBusy  output  1  high in ACCUM state.
- oOverflow  output  1  sticky; set when a sum exceeded 2^ACC_W − 1 during the current run.

## Operation
- Clock and reset: one clock (Clock); Reset is asynchronous and active-low.
- States: IDLE, ACCUM, DONE.
- IDLE: oReady=0.
  - iStart=1 and iLength≠0: clear oAccum and oOverflow, load counter with iLength, go to ACCUM.
  - iStart=1 and iLength=0: clear oAccum and oOverflow, go to DONE.
  - iStart=0: stay in IDLE; oAccum holds its value.
- ACCUM: oReady=1, oBusy=1.
  - Accept when iValid&&oReady: oAccum ← oAccum + zero-extended iProduct; counter decrements.
  - Accept with counter==1: go to DONE.
  - iValid=0: no change.
  - iStart is ignored.
- DONE: oDone=1 for exactly one cycle, then go to IDLE unconditionally. iStart is ignored in DONE.
- Overflow: carry out of bit ACC_W−1 on any add sets oOverflow. oOverflow stays set until the next accepted start or Reset.
- oAccum stays stable after DONE until the next accepted iStart.

## Timing
- Reset asserted, at any time including mid-run:
  - state=IDLE; oAccum=0, oDone=0, oBusy=0, oReady=0, oOverflow=0; counter=0.
  - Any in-flight run is aborted.
- oReady and oBusy are decoded from the registered state only; no combinational path from iValid.
- Start to first accept: iStart in cycle t, oReady=1 in cycle t+1.
- Accumulate latency: a product accepted at edge k appears in oAccum after edge k. Throughput is one product per cycle.
- Final accept at edge k: oDone=1 and oAccum final during cycle k+1; oReady=0 from cycle k+1.
- iLength=0: oDone=1 in cycle t+1 with oAccum=0.
- Back-to-back runs: iStart in the first IDLE cycle after DONE is accepted. Minimum run period is iLength+2 cycles.

## Configuration
- IMUL_ACC_SAT_EN defined:
  - On overflow, oAccum clamps to 2^ACC_W − 1 and stays clamped for the rest of the run.
  - oOverflow is still set.
- IMUL_ACC_SAT_EN undefined: oAccum wraps modulo 2^ACC_W; oOverflow is set.

## Test plan
- Reset mid-run: iLength=5, accept 2 products, assert Reset → all outputs 0 immediately (asynchronous). After release, stays in IDLE with oReady=0.
- Basic run: iLength=3, products 6, 35, 0xFFFE0001 with iValid held high → oDone pulses one cycle after the 3rd accept; oAccum=0xFFFE002A; oOverflow=0.
- Handshake gaps: iLength=4, products of 10 each, iValid toggled 1,0,0,1,1,0,1 → exactly 4 accepts, oAccum=40, oDone only after the 4th. A product presented in DONE/IDLE is not accepted.
- Zero length and ignored start: iLength=0 → oDone in the next cycle with oAccum=0. An iStart pulse during ACCUM leaves the counter and oAccum unchanged.
- Overflow, ACC_W=33: two products of 0xFFFFFFFF plus one of 0x2.
  - Without macro: oAccum=0x0 after wrap, oOverflow=1.
  - With IMUL_ACC_SAT_EN: oAccum=0x1FFFFFFFF, oOverflow=1.
- Back-to-back: a run with iLength=2 immediately followed by a run with iLength=1 (iStart in the first IDLE cycle) → the second run clears oAccum and oOverflow; second oDone comes 3 cycles after the first.
